// File: rtl/mc6809_pkg.sv
// Shared definitions for the 6809 clock generator: sequencer states, quadrant
// encoding and the (Q,E) output levels held during each quadrant.
package mc6809_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    RESET,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    QUAD_0,
    QUAD_1,
    QUAD_2,
    QUAD_3
  } quad_t;

  // {Q, E} per quadrant
  localparam logic [1:0] QE_QUAD_0 = 2'b10;
  localparam logic [1:0] QE_QUAD_1 = 2'b11;
  localparam logic [1:0] QE_QUAD_2 = 2'b01;
  localparam logic [1:0] QE_QUAD_3 = 2'b00;

  function automatic logic [1:0] quad_levels(input quad_t quad);
    logic [1:0] qe;
    case (quad)
      QUAD_0:  qe = QE_QUAD_0;
      QUAD_1:  qe = QE_QUAD_1;
      QUAD_2:  qe = QE_QUAD_2;
      default: qe = QE_QUAD_3;
    endcase
    return qe;
  endfunction

endpackage

// File: rtl/mc6809_clkgen_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; resets to 0.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/mc6809_clkgen.sv
// 6809 E/Q quadrature clock generator with lock-gated CPU reset sequencing.
// Define MC6809_CLKGEN_MRDY_EN to compile in the MRDY stretch of E-high.
module mc6809_clkgen
  import mc6809_pkg::*;
#(
  parameter int DIV          = 1,
  parameter int RESET_CYCLES = 16,
  parameter int MAX_STRETCH  = 40
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pll_lock,
  input  logic mrdy,
  output logic e_clk,
  output logic q_clk,
  output logic e_rise,
  output logic e_fall,
  output logic q_rise,
  output logic cpu_reset_n
);

  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [PW-1:0]  PHASE_LAST = PW'(DIV - 1);
  localparam logic [RCW-1:0] ECNT_LAST  = RCW'(RESET_CYCLES - 1);

  state_t         r_state;
  quad_t          r_quad;
  logic [PW-1:0]  r_phase;
  logic [RCW-1:0] r_ecnt;

  logic  w_lock_sync;
  logic  w_stretch;
  logic  w_last;
  logic  w_repeat;
  quad_t w_next_quad;

  sync2 u_lock_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (pll_lock),
    .o_q     (w_lock_sync)
  );

`ifdef MC6809_CLKGEN_MRDY_EN
  localparam int SW = (MAX_STRETCH > 0) ? $clog2(MAX_STRETCH + 1) : 1;

  logic          w_mrdy_sync;
  logic [SW-1:0] r_stretch;

  sync2 u_mrdy_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (mrdy),
    .o_q     (w_mrdy_sync)
  );

  assign w_stretch = !w_mrdy_sync && (r_stretch < SW'(MAX_STRETCH));
`else
  logic w_unused_mrdy;
  assign w_unused_mrdy = mrdy;
  assign w_stretch     = 1'b0;
`endif

  always_comb begin
    w_last      = (r_phase == PHASE_LAST);
    w_repeat    = w_last && (r_quad == QUAD_2) && w_stretch;
    w_next_quad = w_repeat ? QUAD_2 : quad_t'(r_quad + 2'd1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= WAIT_LOCK;
      r_quad      <= QUAD_0;
      r_phase     <= '0;
      r_ecnt      <= '0;
      e_clk       <= 1'b0;
      q_clk       <= 1'b0;
      e_rise      <= 1'b0;
      e_fall      <= 1'b0;
      q_rise      <= 1'b0;
      cpu_reset_n <= 1'b0;
`ifdef MC6809_CLKGEN_MRDY_EN
      r_stretch   <= '0;
`endif
    end else if (!w_lock_sync) begin
      r_state     <= WAIT_LOCK;
      r_quad      <= QUAD_0;
      r_phase     <= '0;
      r_ecnt      <= '0;
      e_clk       <= 1'b0;
      q_clk       <= 1'b0;
      e_rise      <= 1'b0;
      e_fall      <= 1'b0;
      q_rise      <= 1'b0;
      cpu_reset_n <= 1'b0;
`ifdef MC6809_CLKGEN_MRDY_EN
      r_stretch   <= '0;
`endif
    end else if (r_state == WAIT_LOCK) begin
      // Lock seen: quad 0 levels are loaded on this same edge
      r_state          <= RESET;
      r_quad           <= QUAD_0;
      r_phase          <= '0;
      {q_clk, e_clk}   <= QE_QUAD_0;
      q_rise           <= 1'b1;
      e_rise           <= 1'b0;
      e_fall           <= 1'b0;
    end else begin
      q_rise <= 1'b0;
      e_rise <= 1'b0;
      e_fall <= 1'b0;
      if (w_last) begin
        r_phase        <= '0;
        r_quad         <= w_next_quad;
        {q_clk, e_clk} <= quad_levels(w_next_quad);
        q_rise         <= (w_next_quad == QUAD_0);
        e_rise         <= (w_next_quad == QUAD_1);
        e_fall         <= (w_next_quad == QUAD_3);
        if ((w_next_quad == QUAD_3) && (r_state == RESET)) begin
          if (r_ecnt == ECNT_LAST) begin
            r_state     <= RUN;
            cpu_reset_n <= 1'b1;
          end else begin
            r_ecnt <= r_ecnt + RCW'(1);
          end
        end
`ifdef MC6809_CLKGEN_MRDY_EN
        if (w_repeat) begin
          r_stretch <= r_stretch + SW'(1);
        end else if (w_next_quad == QUAD_3) begin
          r_stretch <= '0;
        end
`endif
      end else begin
        r_phase <= r_phase + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc6809_clkgen.sv
// Self-checking bench for mc6809_clkgen (DIV=2, RESET_CYCLES=4, MAX_STRETCH=8).
module tb_mc6809_clkgen;

  localparam int DIV = 2;
  localparam int RC  = 4;
  localparam int MS  = 8;
`ifdef MC6809_CLKGEN_MRDY_EN
  localparam bit STRETCH_ON = 1'b1;
`else
  localparam bit STRETCH_ON = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n, pll_lock, mrdy;
  logic e_clk, q_clk, e_rise, e_fall, q_rise, cpu_reset_n;

  mc6809_clkgen #(.DIV(DIV), .RESET_CYCLES(RC), .MAX_STRETCH(MS)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pll_lock    (pll_lock),
    .mrdy        (mrdy),
    .e_clk       (e_clk),
    .q_clk       (q_clk),
    .e_rise      (e_rise),
    .e_fall      (e_fall),
    .q_rise      (q_rise),
    .cpu_reset_n (cpu_reset_n)
  );

  always #5 sys_clk = ~sys_clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Reference model: lock/mrdy seen two edges late; E cycle played out as a
  // queue of per-cycle (Q,E) levels, strobes derived from level changes.
  bit        h_l1, h_l2, h_m1, h_m2;
  bit        m_run;
  int        m_quarter, m_nstr, m_efalls;
  bit        m_q, m_e, m_qr, m_er, m_ef, m_crn;
  bit [1:0]  m_lvq[$];

  function automatic void model_reset();
    h_l1 = 0; h_l2 = 0; h_m1 = 0; h_m2 = 0;
    m_run = 0; m_quarter = 0; m_nstr = 0; m_efalls = 0;
    m_q = 0; m_e = 0; m_qr = 0; m_er = 0; m_ef = 0; m_crn = 0;
    m_lvq.delete();
  endfunction

  function automatic void push_quarter(input int qtr);
    bit [1:0] lv;
    lv[1] = (qtr < 2);
    lv[0] = (qtr == 1) || (qtr == 2);
    for (int i = 0; i < DIV; i++) m_lvq.push_back(lv);
  endfunction

  function automatic void model_step(input bit pll, input bit mr);
    bit l, m, pq, pe;
    bit [1:0] lv;
    l = h_l2; h_l2 = h_l1; h_l1 = pll;
    m = h_m2; h_m2 = h_m1; h_m1 = mr;
    pq = m_q; pe = m_e;
    if (!l) begin
      m_run = 0; m_lvq.delete(); m_nstr = 0; m_efalls = 0;
      m_q = 0; m_e = 0; m_qr = 0; m_er = 0; m_ef = 0; m_crn = 0;
      return;
    end
    if (!m_run) begin
      m_run = 1; m_quarter = 0; m_nstr = 0;
      push_quarter(0);
    end else if (m_lvq.size() == 0) begin
      if (m_quarter == 2 && STRETCH_ON && !m && m_nstr < MS) begin
        m_nstr++;
      end else begin
        m_quarter = (m_quarter + 1) % 4;
        if (m_quarter == 3) m_nstr = 0;
      end
      push_quarter(m_quarter);
    end
    lv = m_lvq.pop_front();
    m_q = lv[1]; m_e = lv[0];
    m_qr = m_q && !pq;
    m_er = m_e && !pe;
    m_ef = !m_e && pe;
    if (m_ef) begin
      m_efalls++;
      if (m_efalls >= RC) m_crn = 1;
    end
  endfunction

  task automatic tick();
    @(negedge sys_clk);
    if (!sys_rst_n) model_reset();
    else model_step(pll_lock, mrdy);
    cyc++;
    check("model_outputs", int'({q_clk, e_clk, q_rise, e_rise, e_fall, cpu_reset_n}),
          int'({m_q, m_e, m_qr, m_er, m_ef, m_crn}));
  endtask

  typedef struct {
    int       n;
    bit       pll;
    bit       mr;
    bit [5:0] exp;  // {q, e, q_rise, e_rise, e_fall, cpu_reset_n}
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   t, n, hi, rise_t, qrise_t, fall_cnt;
    bit   pe, pq, ok;

    vecs = '{
      '{1,  1, 1, 6'b000000}, '{2,  1, 1, 6'b000000}, '{3,  1, 1, 6'b101000},
      '{4,  1, 1, 6'b100000}, '{5,  1, 1, 6'b110100}, '{6,  1, 1, 6'b110000},
      '{7,  1, 1, 6'b010000}, '{8,  1, 1, 6'b010000}, '{9,  1, 1, 6'b000010},
      '{10, 1, 1, 6'b000000}, '{11, 1, 1, 6'b101000}, '{32, 1, 1, 6'b010000},
      '{33, 1, 1, 6'b000011}, '{34, 1, 1, 6'b000001}, '{35, 1, 1, 6'b101001}
    };

    sys_rst_n = 0; pll_lock = 1; mrdy = 1;
    model_reset();
    #1;
    check("reset_outputs", int'({q_clk, e_clk, q_rise, e_rise, e_fall, cpu_reset_n}), 0);
    tick(); tick();
    sys_rst_n = 1;
    cyc = 0;

    // Power-up sequence from lock already present
    foreach (vecs[i]) begin
      pll_lock = vecs[i].pll; mrdy = vecs[i].mr;
      while (cyc < vecs[i].n) tick();
      check($sformatf("startup_edge%0d", vecs[i].n),
            int'({q_clk, e_clk, q_rise, e_rise, e_fall, cpu_reset_n}), int'(vecs[i].exp));
    end

    // Ten E periods of free running
    pe = e_clk; pq = q_clk; rise_t = -1; qrise_t = -1; t = 0;
    for (int i = 0; i < 10 * 4 * DIV + 2; i++) begin
      tick(); t++;
      check("e_rise_strobe", int'(e_rise), int'(e_clk && !pe));
      check("e_fall_strobe", int'(e_fall), int'(!e_clk && pe));
      check("q_rise_strobe", int'(q_rise), int'(q_clk && !pq));
      if (q_clk && !pq) begin
        if (qrise_t >= 0) check("q_period", t - qrise_t, 4 * DIV);
        qrise_t = t;
      end
      if (!q_clk && pq && qrise_t >= 0) check("q_high", t - qrise_t, 2 * DIV);
      if (e_clk && !pe) begin
        if (rise_t >= 0) check("e_period", t - rise_t, 4 * DIV);
        if (qrise_t >= 0) check("q_leads_e", t - qrise_t, DIV);
        rise_t = t;
      end
      if (!e_clk && pe && rise_t >= 0) check("e_high", t - rise_t, 2 * DIV);
      pe = e_clk; pq = q_clk;
    end

    // Lock lost in RUN, then regained
    pll_lock = 0;
    tick(); tick();
    check("lock_drop_2edges_crn", int'(cpu_reset_n), 1);
    tick();
    check("lock_drop_clocks", int'({q_clk, e_clk, cpu_reset_n}), 0);
    tick();
    pll_lock = 1;
    n = 0; ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin tick(); n++; ok = q_rise; end
    check("relock_to_q_rise", n, 3);
    n = 0; ok = 0; fall_cnt = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(); n++;
      if (e_fall) fall_cnt++;
      ok = cpu_reset_n;
    end
    check("relock_reset_len", n, 30);
    check("relock_reset_falls", fall_cnt, RC);
    check("relock_crn_with_fall", int'(e_fall), 1);

    // Two stretch samples with mrdy low
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = e_rise; end
    check("wait_e_rise_a", int'(ok), 1);
    mrdy = 0;
    hi = 0;
    for (int i = 0; i < 4; i++) begin tick(); hi++; end
    mrdy = 1;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (e_fall) ok = 1;
      else begin tick(); hi++; end
    end
    check("stretch2_e_high", hi, STRETCH_ON ? 4 * DIV : 2 * DIV);

    // mrdy stuck low: capped stretch, then normal
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = e_rise; end
    check("wait_e_rise_b", int'(ok), 1);
    mrdy = 0;
    hi = 0; ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin tick(); hi++; ok = e_fall; end
    mrdy = 1;
    check("stuck_e_high", hi, STRETCH_ON ? (2 + MS) * DIV : 2 * DIV);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = e_rise; end
    hi = 0; ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin tick(); hi++; ok = e_fall; end
    check("after_stuck_e_high", hi, 2 * DIV);

    // Asynchronous reset during E high
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = e_clk; end
    check("wait_e_high", int'(ok), 1);
    #2 sys_rst_n = 0;
    #1;
    check("async_rst_outputs", int'({q_clk, e_clk, q_rise, e_rise, e_fall, cpu_reset_n}), 0);
    tick(); tick();
    sys_rst_n = 1;
    n = 0; ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin tick(); n++; ok = q_rise; end
    check("rst_release_to_q_rise", n, 3);

    // Random mrdy and lock glitches against the model
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      mrdy = ($urandom_range(0, 3) != 0);
      if (n > 0) begin
        n--; pll_lock = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        n = $urandom_range(0, 7); pll_lock = 0;
      end else begin
        pll_lock = 1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
